audio_loop_recorder: RTL

AUDIO_LOOP_RECORDER -- requirements
Module: audio_loop_recorder

---
 rtl/audio_loop_recorder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/audio_loop_recorder.sv
// Loop recorder: decimating averager into a single-port sample memory,
// played back as an endless zero-order-hold loop.
//
// Ports:
//   clk_in        system clock
//   rst_n_in      asynchronous active-low reset
//   ready_in      one-cycle sample strobe
//   record_in     record level (1 = record), debounced upstream
//   mic_in        signed PCM input sample, valid with ready_in
//   data_out      signed PCM playback sample
//   recording_out high while recording
//   playing_out   high while playing
//   length_out    stored-sample count of the last recording
module audio_loop_recorder #(
    parameter int DEPTH = 65536,
    parameter int DECIM = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     ready_in,
    input  logic                     record_in,
    input  logic [7:0]               mic_in,
    output logic [7:0]               data_out,
    output logic                     recording_out,
    output logic                     playing_out,
    output logic [$clog2(DEPTH):0]   length_out
);

    localparam int AB = $clog2(DEPTH);
    localparam int DB = $clog2(DECIM);
    localparam int SW = 8 + DB;
    localparam logic [DB-1:0] CNT_MAX = DB'(DECIM - 1);
    localparam logic [AB-1:0] ADDR_MAX = AB'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        PLAY
    } state_t;

    state_t state;

    logic                 rec_q;
    logic                 rec_d;
    logic                 rise;
    logic                 fall;
    logic [AB-1:0]        wr_addr;
    logic [AB-1:0]        rd_addr;
    logic [AB-1:0]        mem_addr;
    logic [DB-1:0]        cnt;
    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] sum;
    logic [7:0]           wdata;
    logic                 mem_we;
    logic [7:0]           rd_data;
    logic                 pend;
    logic [7:0]           mem [DEPTH];

    assign rise = rec_q & ~rec_d;
    assign fall = ~rec_q & rec_d;

    // Running sum including the current sample; the shift floors toward -inf.
    assign sum   = acc + $signed({{DB{mic_in[7]}}, mic_in});
    assign wdata = 8'(sum >>> DB);

    // A strobe that coincides with an applied record edge is dropped.
    assign mem_we = (state == RECORD) && ready_in && !rise && !fall
                    && (cnt == CNT_MAX);

    // One shared address port keeps the memory single-port.
    assign mem_addr = (state == RECORD) ? wr_addr : rd_addr;

    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem[mem_addr] <= wdata;
        end
        rd_data <= mem[mem_addr];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            rec_q         <= 1'b0;
            rec_d         <= 1'b0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            cnt           <= '0;
            acc           <= '0;
            pend          <= 1'b0;
            data_out      <= '0;
            recording_out <= 1'b0;
            playing_out   <= 1'b0;
            length_out    <= '0;
        end else begin
            rec_q <= record_in;
            rec_d <= rec_q;
            pend  <= 1'b0;
            if (rise) begin
                state         <= RECORD;
                recording_out <= 1'b1;
                playing_out   <= 1'b0;
                wr_addr       <= '0;
                cnt           <= '0;
                acc           <= '0;
                data_out      <= '0;
            end else if (fall && state == RECORD) begin
                length_out    <= {1'b0, wr_addr};
                cnt           <= '0;
                acc           <= '0;
                rd_addr       <= '0;
                data_out      <= '0;
                recording_out <= 1'b0;
                if (wr_addr != '0) begin
                    state       <= PLAY;
                    playing_out <= 1'b1;
                end else begin
                    state       <= IDLE;
                    playing_out <= 1'b0;
                end
            end else begin
                // Second stage of the read pipeline: memory, then output.
                if (pend && state == PLAY) begin
                    data_out <= rd_data;
                end
                unique case (state)
                    RECORD: begin
                        if (ready_in) begin
                            if (cnt == CNT_MAX) begin
                                acc     <= '0;
                                cnt     <= '0;
                                wr_addr <= wr_addr + 1'b1;
                                if (wr_addr == ADDR_MAX) begin
                                    length_out    <= (AB + 1)'(DEPTH);
                                    state         <= PLAY;
                                    recording_out <= 1'b0;
                                    playing_out   <= 1'b1;
                                    rd_addr       <= '0;
                                end
                            end else begin
                                acc <= sum;
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    PLAY: begin
                        if (ready_in) begin
                            pend <= 1'b1;
                            if (cnt == CNT_MAX) begin
                                cnt <= '0;
                                if ({1'b0, rd_addr} == length_out - 1'b1) begin
                                    rd_addr <= '0;
                                end else begin
                                    rd_addr <= rd_addr + 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
